l2cache_tagv_maint: RTL

Maintenance sequencer that drives the write side of the L2 cache tag/valid array. It owns all tag-array writes that are not part of the normal refill path: the post-reset clear sweep, invalidate-all, index-invalidate, hit-invalidate, and direct tag stores issued by the L2 control FSM for cache ops. It sits between the L2 control FSM (request/ready handshake) and the 4-way tag/valid array. For hit-invalidate it uses the array's read/compare port.

---
 rtl/l2cache_tagv_maint_if.sv | 32 +++
 rtl/l2cache_tagv_maint.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/l2cache_tagv_maint_if.sv
// Request/status bus between the L2 control FSM and the tag/valid
// maintenance sequencer.
//   op_valid / op_ready : request handshake, accepted when both are high
//   op_type             : 0 invalidate-all, 1 index-invalidate,
//                         2 hit-invalidate, 3 store-tag
//   op_index / op_way   : target set / target way
//   op_tag              : compare tag (hit-invalidate) or write tag (store-tag)
//   busy / done         : sequencer activity, one-cycle completion pulse
// The master modport is the control FSM; the slave modport is the sequencer.
interface l2cache_tagv_maint_if #(
  parameter int addr_width = 4,
  parameter int data_width = 25
);
  logic                  op_valid;
  logic                  op_ready;
  logic [1:0]            op_type;
  logic [addr_width-1:0] op_index;
  logic [1:0]            op_way;
  logic [data_width-1:0] op_tag;
  logic                  busy;
  logic                  done;

  modport master (
    output op_valid, op_type, op_index, op_way, op_tag,
    input  op_ready, busy, done
  );

  modport slave (
    input  op_valid, op_type, op_index, op_way, op_tag,
    output op_ready, busy, done
  );
endinterface

// File: rtl/l2cache_tagv_maint.sv
// Tag/valid array maintenance sequencer. Owns every tag-array write outside
// the refill path: the clear sweep after reset, invalidate-all, index
// invalidate, hit invalidate (through the array's read/compare port) and
// direct tag stores.
//   clk, rst          : clock, asynchronous active-high reset
//   op (slave)        : request handshake plus busy/done status
//   TagV_init         : {enable, way} zero tag + clear valid for one way
//   TagV_addr_write   : write set
//   TagV_din_write    : write tag
//   TagV_we           : per-way tag write + set valid
//   TagV_unvalid      : per-way clear valid
//   TagV_addr_read    : lookup set
//   TagV_din_compare  : lookup tag
//   TagV_way_select   : readback way (latched op_way)
//   hit               : per-way hit, one cycle after the lookup address
// All outputs are decoded from registered state; nothing depends
// combinationally on the op_* request fields.
module l2cache_tagv_maint #(
  parameter int addr_width = 4,
  parameter int data_width = 25,
  parameter int way        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  l2cache_tagv_maint_if.slave   op,
  output logic [2:0]            TagV_init,
  output logic [addr_width-1:0] TagV_addr_write,
  output logic [data_width-1:0] TagV_din_write,
  output logic [way-1:0]        TagV_we,
  output logic [way-1:0]        TagV_unvalid,
  output logic [addr_width-1:0] TagV_addr_read,
  output logic [data_width-1:0] TagV_din_compare,
  output logic [1:0]            TagV_way_select,
  input  logic [way-1:0]        hit
);

  typedef enum logic [2:0] {
    S_SWEEP   = 3'd0,
    S_IDLE    = 3'd1,
    S_WRITE   = 3'd2,
    S_LOOKUP  = 3'd3,
    S_COMPARE = 3'd4
  } state_t;

  localparam int               CNT_W    = addr_width + 2;
  localparam logic [CNT_W-1:0] CNT_LAST = '1;
  localparam logic [1:0]       OP_INV_ALL = 2'd0;
  localparam logic [1:0]       OP_HIT_INV = 2'd2;
  localparam logic [1:0]       OP_STORE   = 2'd3;

  state_t                state_q, state_d;
  logic                  run_q, run_d;
  // {set, way} sweep counter; low two bits are the way
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            type_q, type_d;
  logic [1:0]            way_q, way_d;
  logic [addr_width-1:0] idx_q, idx_d;
  logic [data_width-1:0] tag_q, tag_d;

  logic                  accept;
  logic [way-1:0]        way_oh;
  logic                  ready_o, busy_o, done_o;
  logic [addr_width-1:0] addr_wr;

  assign accept = (state_q == S_IDLE) && op.op_valid;
  assign way_oh = {{(way-1){1'b0}}, 1'b1} << way_q;

  // State register (control flops)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_SWEEP;
      run_q   <= 1'b0;
      cnt_q   <= '0;
      type_q  <= 2'd0;
      way_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      way_q   <= way_d;
    end
  end

  // Latched request payload; only observed while gated by state
  always_ff @(posedge clk) begin
    idx_q <= idx_d;
    tag_q <= tag_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    // run_q holds the sweep off while reset is asserted so every output
    // except busy reads 0 during reset; the sweep starts on the first clock
    run_d   = 1'b1;
    cnt_d   = cnt_q;
    type_d  = type_q;
    way_d   = way_q;
    idx_d   = idx_q;
    tag_d   = tag_q;
    case (state_q)
      S_SWEEP: begin
        if (run_q) begin
          // increments from CNT_LAST wrap to 0 exactly at terminal count
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (accept) begin
          type_d = op.op_type;
          way_d  = op.op_way;
          idx_d  = op.op_index;
          tag_d  = op.op_tag;
          case (op.op_type)
            OP_INV_ALL: begin
              state_d = S_SWEEP;
              cnt_d   = '0;
            end
            OP_HIT_INV: state_d = S_LOOKUP;
            default:    state_d = S_WRITE;
          endcase
        end
      end
      S_WRITE:   state_d = S_IDLE;
      S_LOOKUP:  state_d = S_COMPARE;
      S_COMPARE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    ready_o          = 1'b0;
    busy_o           = 1'b1;
    done_o           = 1'b0;
    TagV_init        = 3'b000;
    addr_wr          = '0;
    TagV_din_write   = '0;
    TagV_we          = '0;
    TagV_unvalid     = '0;
    TagV_addr_read   = '0;
    TagV_din_compare = '0;
    case (state_q)
      S_SWEEP: begin
        if (run_q) begin
          TagV_init = {1'b1, cnt_q[1:0]};
          addr_wr   = cnt_q[CNT_W-1:2];
          done_o    = (cnt_q == CNT_LAST);
        end
      end
      S_IDLE: begin
        ready_o = 1'b1;
        busy_o  = 1'b0;
      end
      S_WRITE: begin
        addr_wr = idx_q;
        done_o  = 1'b1;
        if (type_q == OP_STORE) begin
          TagV_we        = way_oh;
          TagV_din_write = tag_q;
        end else begin
          TagV_unvalid = way_oh;
        end
      end
      S_LOOKUP: begin
        TagV_din_compare = tag_q;
      end
      S_COMPARE: begin
        // raw hit vector: a miss clears nothing, multiple hits clear all
        addr_wr          = idx_q;
        TagV_unvalid     = hit;
        TagV_din_compare = tag_q;
        done_o           = 1'b1;
      end
      default: begin
        busy_o = 1'b1;
      end
    endcase
    // the read port mirrors the write address except during a lookup
    if (state_q == S_LOOKUP || state_q == S_COMPARE) TagV_addr_read = idx_q;
    else                                             TagV_addr_read = addr_wr;
  end

  assign TagV_addr_write = addr_wr;
  assign TagV_way_select = way_q;
  assign op.op_ready     = ready_o;
  assign op.busy         = busy_o;
  assign op.done         = done_o;

endmodule
